// File: rtl/imem_program_loader_if.sv
// imem_program_loader_if: byte-stream input, imem write port and core-control status of the loader
interface imem_program_loader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);
  logic start;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;
  logic cpu_hold;
  logic busy;
  logic done;
  logic error;
  modport master (
    output start, in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error
  );
  modport slave (
    input  start, in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error
  );
endinterface

// File: rtl/imem_program_loader.sv
// imem_program_loader: loads a LEN/data/XOR-checksum byte frame into imem and holds the core until it succeeds
module imem_program_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  imem_program_loader_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, WR, CSUM, DONE, ERR} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0] csum;
  logic [7:0] hi;
  assign bus.in_ready = state == LEN || state == HI || state == LO || state == CSUM;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      csum <= '0;
      hi <= '0;
      bus.imem_we <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_wdata <= '0;
      bus.cpu_hold <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR:
          if (bus.start) begin
            state <= LEN;
            bus.busy <= 1'b1;
            bus.cpu_hold <= 1'b1;
            bus.done <= 1'b0;
            bus.error <= 1'b0;
          end
        LEN:
          if (bus.in_valid) begin
            if (bus.in_data == 8'd0 || int'(bus.in_data) > DEPTH) begin
              state <= ERR;
              bus.error <= 1'b1;
              bus.busy <= 1'b0;
            end else begin
              state <= HI;
              cnt <= CW'(bus.in_data);
              addr <= '0;
              csum <= '0;
            end
          end
        HI:
          if (bus.in_valid) begin
            hi <= bus.in_data;
            csum <= csum ^ bus.in_data;
            state <= LO;
          end
        // the write strobe is registered here so it is high exactly during WR
        LO:
          if (bus.in_valid) begin
            csum <= csum ^ bus.in_data;
            bus.imem_we <= 1'b1;
            bus.imem_addr <= addr;
            bus.imem_wdata <= DATA_WIDTH'({hi, bus.in_data});
            state <= WR;
          end
        WR: begin
          addr <= addr + 1'b1;
          cnt <= cnt - 1'b1;
          state <= cnt == CW'(1) ? CSUM : HI;
        end
        CSUM:
          if (bus.in_valid) begin
            state <= bus.in_data == csum ? DONE : ERR;
            bus.done <= bus.in_data == csum;
            bus.error <= bus.in_data != csum;
            bus.cpu_hold <= bus.in_data != csum;
            bus.busy <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: directed frames against hand-computed imem writes and status flags
module tb_imem_program_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [19:0] wlog[$];
  imem_program_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus ();
  imem_program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.imem_we === 1'b1) wlog.push_back({bus.imem_addr, bus.imem_wdata});
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int gap = 0, input bit poke = 1'b0);
    int n = 0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.start = poke && i == 0;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_data = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic t2_frame(input logic [7:0] cs);
    pulse_start();
    send(8'h02);
    send(8'h12);
    send(8'h34);
    send(8'hAB);
    send(8'hCD);
    send(cs);
  endtask
  task automatic status(input string tag, input logic d, input logic e, input logic h, input logic b);
    chk({tag, "_done"}, 32'(bus.done), 32'(d));
    chk({tag, "_error"}, 32'(bus.error), 32'(e));
    chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'(h));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(b));
  endtask
  initial begin
    bus.start = 1'b0;
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    // T1: asynchronous reset before any clock edge
    #3 rst_n = 1'b0;
    #1;
    status("t1", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_we", 32'(bus.imem_we), 32'd0);
    chk("t1_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // T2: good two-word load, with write latency and cycle-level checks
    wlog.delete();
    pulse_start();
    status("t2_start", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t2_ready_len", 32'(bus.in_ready), 32'd1);
    send(8'h02);
    send(8'h12);
    send(8'h34);
    chk("t2_we_lat", 32'(bus.imem_we), 32'd1);
    chk("t2_addr0", 32'(bus.imem_addr), 32'h0);
    chk("t2_data0", 32'(bus.imem_wdata), 32'h1234);
    chk("t2_ready_wr", 32'(bus.in_ready), 32'd0);
    send(8'hAB);
    send(8'hCD);
    send(8'h40);
    status("t2", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_nwr", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("t2_w0", 32'(wlog[0]), 32'h01234);
      chk("t2_w1", 32'(wlog[1]), 32'h1ABCD);
    end
    // T3: bad checksum
    wlog.delete();
    t2_frame(8'h41);
    status("t3", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t3_nwr", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) chk("t3_w1", 32'(wlog[1]), 32'h1ABCD);
    // T4: bad lengths 0, 17 and 0x17
    wlog.delete();
    pulse_start();
    send(8'h00);
    status("t4_len0", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_ready_err", 32'(bus.in_ready), 32'd0);
    pulse_start();
    send(8'h11);
    status("t4_len17", 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_start();
    send(8'h17);
    status("t4_len23", 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("t4_nwr", 32'(wlog.size()), 32'd0);
    // T5: full depth with stalls and ignored start pulses
    wlog.delete();
    pulse_start();
    send(8'h10, $urandom_range(0, 3));
    for (int k = 0; k < 16; k++) begin
      send(8'h10, (k % 5 == 2) ? $urandom_range(1, 3) : $urandom_range(0, 3), k % 5 == 2);
      send(8'(k), $urandom_range(0, 3));
    end
    send(8'h00, $urandom_range(1, 3), 1'b1);
    repeat (4) @(negedge clk);
    status("t5", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_nwr", 32'(wlog.size()), 32'd16);
    for (int k = 0; k < 16 && k < wlog.size(); k++)
      chk($sformatf("t5_w%0d", k), 32'(wlog[k]), {12'h0, 4'(k), 16'h1000 + 16'(k)});
    // T6: reset mid-frame, then a clean reload
    wlog.delete();
    pulse_start();
    send(8'h02);
    send(8'h12);
    send(8'h34);
    send(8'hAB);
    #2 rst_n = 1'b0;
    #1;
    status("t6_rst", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_we", 32'(bus.imem_we), 32'd0);
    chk("t6_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_data = 8'hCD;
    bus.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t6_nwr", 32'(wlog.size()), 32'd1);
    wlog.delete();
    t2_frame(8'h40);
    status("t6_reload", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_reload_nwr", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("t6_w0", 32'(wlog[0]), 32'h01234);
      chk("t6_w1", 32'(wlog[1]), 32'h1ABCD);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
